// File: rtl/uart_link_param.sv
// Parametrised UART transceiver with independent TX and RX paths on one clock.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_link_param #(
    parameter int unsigned DATA_W       = 7,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_parity_err,
    output logic              rx_frame_err
);

`ifdef UART_PARITY_EN
    localparam int unsigned P = 1;
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxBreak} rx_state_e;
`else
    localparam int unsigned P = 0;
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;
`endif

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BW = $clog2(DATA_W + 1);
    localparam int unsigned FW = 1 + DATA_W + P + STOP_BITS;
    localparam logic [CW-1:0] CntLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CntHalf  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CntFull  = CW'(CLKS_PER_BIT);
    localparam logic [BW-1:0] DataLast = BW'(DATA_W - 1);
    localparam logic [BW-1:0] StopLast = BW'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_link_param: illegal parameter set");
    end

    // ---------------- TX ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]     tx_bit_q, tx_bit_d;
    logic [FW-1:0]     tx_shift_q, tx_shift_d;
    logic [FW-1:0]     tx_frame;
    logic              tx_bit_end;
    logic              tx_accept;

`ifdef UART_PARITY_EN
    logic tx_par;
    assign tx_par   = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
    assign tx_frame = {{STOP_BITS{1'b1}}, tx_par, tx_data, 1'b0};
`else
    assign tx_frame = {{STOP_BITS{1'b1}}, tx_data, 1'b0};
`endif

    assign tx_accept = tx_valid & tx_ready;
    // The shift register refills with ones, so its LSB is a registered idle-high txd.
    assign txd       = tx_shift_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state_q <= TxIdle;
        else        tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TxIdle:   if (tx_valid) tx_state_d = TxStart;
            TxStart:  if (tx_bit_end) tx_state_d = TxData;
`ifdef UART_PARITY_EN
            TxData:   if (tx_bit_end && tx_bit_q == DataLast) tx_state_d = TxParity;
            TxParity: if (tx_bit_end) tx_state_d = TxStop;
`else
            TxData:   if (tx_bit_end && tx_bit_q == DataLast) tx_state_d = TxStop;
`endif
            TxStop:   if (tx_bit_end && tx_bit_q == StopLast) tx_state_d = TxIdle;
            default:  tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        tx_ready   = (tx_state_q == TxIdle);
        tx_bit_end = (tx_state_q != TxIdle) && (tx_cnt_q == CntLast);
    end

    always_comb begin
        tx_cnt_d = (tx_ready || tx_bit_end) ? '0 : tx_cnt_q + CW'(1);
        tx_bit_d = tx_bit_q;
        if (tx_state_d != tx_state_q) tx_bit_d = '0;
        else if (tx_bit_end)          tx_bit_d = tx_bit_q + BW'(1);
        tx_shift_d = tx_shift_q;
        if (tx_accept)       tx_shift_d = tx_frame;
        else if (tx_bit_end) tx_shift_d = {1'b1, tx_shift_q[FW-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // ---------------- RX ----------------
    rx_state_e         rx_state_q, rx_state_d;
    logic [1:0]        rx_sync_q;
    logic              rx_in;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              rx_stop_err_q, rx_stop_err_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_frame_err_q, rx_frame_err_d;
    logic              rx_sample, rx_done, rx_stop_bad;

    assign rx_in = rx_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state_q <= RxIdle;
        else        rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RxIdle:   if (!rx_in) rx_state_d = RxStart;
            RxStart:  if (rx_sample) rx_state_d = rx_in ? RxIdle : RxData;
`ifdef UART_PARITY_EN
            RxData:   if (rx_sample && rx_bit_q == DataLast) rx_state_d = RxParity;
            RxParity: if (rx_sample) rx_state_d = RxStop;
`else
            RxData:   if (rx_sample && rx_bit_q == DataLast) rx_state_d = RxStop;
`endif
            RxStop:   if (rx_done) rx_state_d = rx_stop_bad ? RxBreak : RxIdle;
            RxBreak:  if (rx_in) rx_state_d = RxIdle;
            default:  rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        rx_sample   = (rx_state_q != RxIdle) && (rx_state_q != RxBreak) &&
                      (rx_cnt_q == CW'(1));
        rx_done     = (rx_state_q == RxStop) && rx_sample && (rx_bit_q == StopLast);
        rx_stop_bad = rx_stop_err_q | ~rx_in;
    end

    always_comb begin
        if (rx_state_q == RxIdle)       rx_cnt_d = rx_in ? '0 : CntHalf;
        else if (rx_state_q == RxBreak) rx_cnt_d = '0;
        else if (rx_sample)             rx_cnt_d = CntFull;
        else                            rx_cnt_d = rx_cnt_q - CW'(1);
        rx_bit_d = rx_bit_q;
        if (rx_state_d != rx_state_q) rx_bit_d = '0;
        else if (rx_sample)           rx_bit_d = rx_bit_q + BW'(1);
        rx_shift_d = rx_shift_q;
        if (rx_sample && rx_state_q == RxData) rx_shift_d = {rx_in, rx_shift_q[DATA_W-1:1]};
        rx_stop_err_d = rx_stop_err_q;
        if (rx_state_q != RxStop) rx_stop_err_d = 1'b0;
        else if (rx_sample)       rx_stop_err_d = rx_stop_bad;
        rx_data_d      = rx_done ? rx_shift_q : rx_data_q;
        rx_frame_err_d = rx_done ? rx_stop_bad : rx_frame_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q      <= 2'b11;
            rx_cnt_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_stop_err_q  <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_sync_q      <= {rx_sync_q[0], rxd};
            rx_cnt_q       <= rx_cnt_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
            rx_stop_err_q  <= rx_stop_err_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_done;
            rx_frame_err_q <= rx_frame_err_d;
        end
    end

`ifdef UART_PARITY_EN
    logic rx_par_q, rx_parity_err_q;
    logic rx_par_exp;
    assign rx_par_exp = (PARITY_ODD != 0) ? ~^rx_shift_q : ^rx_shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_par_q        <= 1'b0;
            rx_parity_err_q <= 1'b0;
        end else begin
            if (rx_sample && rx_state_q == RxParity) rx_par_q <= rx_in;
            if (rx_done) rx_parity_err_q <= (rx_par_q != rx_par_exp);
        end
    end
    assign rx_parity_err = rx_parity_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_uart_link_param.sv
// Directed bench for uart_link_param (DATA_W=7, CLKS_PER_BIT=4, STOP_BITS=1) with an RX
// scoreboard; handles builds with and without UART_PARITY_EN.
module tb_uart_link_param;
    localparam int unsigned DW  = 7;
    localparam int unsigned CPB = 4;
    localparam int unsigned SB  = 1;
`ifdef UART_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned FB = 1 + DW + PB + SB;
    localparam int unsigned N  = CPB * FB;
    localparam logic PERR_EXP  = (PB == 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          txd;
    logic          rxd;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_parity_err;
    logic          rx_frame_err;
    logic          loop_en = 1'b1;
    logic          rxd_drv = 1'b1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   rx_count = 0;
    int   base;
    logic [FB-1:0] fr;

    assign rxd = loop_en ? txd : rxd_drv;

    uart_link_param #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB),
        .PARITY_ODD  (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .txd          (txd),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic p, input logic f);
        sb.push_back({d, p, f});
    endtask

    // Even-parity frame; par_flip inverts the parity bit, stop sets the stop bit value.
    function automatic logic [FB-1:0] make_frame(input logic [DW-1:0] d, input logic par_flip,
                                                 input logic stop);
`ifdef UART_PARITY_EN
        return {stop, (^d) ^ par_flip, d, 1'b0};
`else
        return {stop, d, 1'b0};
`endif
    endfunction

    task automatic send_rx(input logic [FB-1:0] f);
        for (int i = 0; i < int'(FB); i++) begin
            rxd_drv = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 32'(sb.size()), 32'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            rx_count++;
            if (sb.size() == 0) begin
                check("rx_unexpected", 32'(rx_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rx_data", 32'(rx_data), 32'(mon_e.data));
                check("rx_parity_err", 32'(rx_parity_err), 32'(mon_e.perr));
                check("rx_frame_err", 32'(rx_frame_err), 32'(mon_e.ferr));
            end
        end
    end

    initial begin
        // Reset values, applied asynchronously
        #1 rst_n = 1'b0;
        #1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_perr", 32'(rx_parity_err), 32'd0);
        check("rst_ferr", 32'(rx_frame_err), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // 1. Loopback of 7'h55
        base = rx_count;
        fr = make_frame(7'h55, 1'b0, 1'b1);
        tx_data = 7'h55;
        tx_valid = 1'b1;
        push(7'h55, 1'b0, 1'b0);
        tick(1);
        tx_valid = 1'b0;
        check("t1_ready_low", 32'(tx_ready), 32'd0);
        for (int i = 0; i < int'(N); i++) begin
            check("t1_txd", 32'(txd), 32'(fr[i/CPB]));
            if (i == int'(N) - 1) check("t1_ready_busy", 32'(tx_ready), 32'd0);
            tick(1);
        end
        check("t1_ready_back", 32'(tx_ready), 32'd1);
        check("t1_txd_idle", 32'(txd), 32'd1);
        wait_drain("t1_drain", 20);
        check("t1_rx_count", 32'(rx_count - base), 32'd1);

        // 2. Back-to-back with tx_valid held high
        base = rx_count;
        tx_data = 7'h01;
        tx_valid = 1'b1;
        push(7'h01, 1'b0, 1'b0);
        tick(1);
        tx_data = 7'h7F;
        tick(N);
        check("t2_gap_ready", 32'(tx_ready), 32'd1);
        check("t2_gap_txd", 32'(txd), 32'd1);
        push(7'h7F, 1'b0, 1'b0);
        tick(1);
        check("t2_second_ready", 32'(tx_ready), 32'd0);
        check("t2_second_start", 32'(txd), 32'd0);
        tx_valid = 1'b0;
        tick(N);
        wait_drain("t2_drain", 30);
        check("t2_rx_count", 32'(rx_count - base), 32'd2);

        // 3. Parity bit forced to 1 on 7'h03, then a correct frame
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        tick(4);
        push(7'h03, PERR_EXP, 1'b0);
        send_rx(make_frame(7'h03, 1'b1, 1'b1));
        wait_drain("t3_drain_bad", 10);
        check("t3_perr_hold", 32'(rx_parity_err), 32'(PERR_EXP));
        push(7'h55, 1'b0, 1'b0);
        send_rx(make_frame(7'h55, 1'b0, 1'b1));
        wait_drain("t3_drain_good", 10);
        check("t3_perr_clear", 32'(rx_parity_err), 32'd0);

        // 4. Frame error followed by a long low line
        base = rx_count;
        push(7'h12, 1'b0, 1'b1);
        send_rx(make_frame(7'h12, 1'b0, 1'b0));
        tick(40);
        wait_drain("t4_drain", 5);
        check("t4_one_valid", 32'(rx_count - base), 32'd1);
        check("t4_ferr_hold", 32'(rx_frame_err), 32'd1);
        rxd_drv = 1'b1;
        tick(4);
        push(7'h21, 1'b0, 1'b0);
        send_rx(make_frame(7'h21, 1'b0, 1'b1));
        wait_drain("t4_drain_recover", 10);
        check("t4_ferr_clear", 32'(rx_frame_err), 32'd0);

        // 5. One-cycle glitch, then 7'h2A
        base = rx_count;
        rxd_drv = 1'b0;
        tick(1);
        rxd_drv = 1'b1;
        tick(12);
        check("t5_no_valid", 32'(rx_count - base), 32'd0);
        push(7'h2A, 1'b0, 1'b0);
        send_rx(make_frame(7'h2A, 1'b0, 1'b1));
        wait_drain("t5_drain", 10);
        check("t5_one_valid", 32'(rx_count - base), 32'd1);

        // 6. Reset during TX data bits in loopback
        loop_en = 1'b1;
        base = rx_count;
        tx_data = 7'h33;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(8);
        rst_n = 1'b0;
        #1;
        check("t6_rst_txd", 32'(txd), 32'd1);
        check("t6_rst_ready", 32'(tx_ready), 32'd1);
        check("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(N + 10);
        check("t6_no_valid", 32'(rx_count - base), 32'd0);
        check("t6_txd_idle", 32'(txd), 32'd1);
        check("t6_ready_idle", 32'(tx_ready), 32'd1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
